// File: rtl/io_input_debouncer.sv
// Synchronises and debounces raw switches and active-low keys; output settles DEBOUNCE_CYCLES+2 edges after a held change.
// Keys additionally provide registered press/release pulses and a clearable sticky press latch.
module io_input_debouncer #(
  parameter int NUM_SW          = 10,
  parameter int NUM_KEY         = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NUM_SW-1:0]  i_sw,
  input  logic [NUM_KEY-1:0] i_key,
  input  logic [NUM_KEY-1:0] i_clr_key,
  output logic [NUM_SW-1:0]  o_sw,
  output logic [NUM_KEY-1:0] o_key_level,
  output logic [NUM_KEY-1:0] o_key_press,
  output logic [NUM_KEY-1:0] o_key_release,
  output logic [NUM_KEY-1:0] o_key_sticky
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int N     = NUM_SW + NUM_KEY;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N-1:0]            s1_q, s1_d;
  logic [N-1:0]            s2_q, s2_d;
  logic [N-1:0]            stable_q, stable_d;
  logic [N-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_KEY-1:0]      press_q, press_d;
  logic [NUM_KEY-1:0]      release_q, release_d;
  logic [NUM_KEY-1:0]      sticky_q, sticky_d;
  logic [NUM_KEY-1:0]      key_new, key_old;

  always_comb begin
    // Keys are inverted up front so every internal bit reads 1 = active.
    s1_d     = {~i_key, i_sw};
    s2_d     = s1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;

    for (int i = 0; i < N; i++) begin
      if (s2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = s2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end

    key_new   = stable_d[N-1:NUM_SW];
    key_old   = stable_q[N-1:NUM_SW];
    press_d   = key_new & ~key_old;
    release_d = ~key_new & key_old;
    // A press in the same cycle as a clear keeps the latch set.
    sticky_d  = press_d | (sticky_q & ~i_clr_key);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      stable_q  <= '0;
      cnt_q     <= '0;
      press_q   <= '0;
      release_q <= '0;
      sticky_q  <= '0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      sticky_q  <= sticky_d;
    end
  end

  assign o_sw          = stable_q[NUM_SW-1:0];
  assign o_key_level   = stable_q[N-1:NUM_SW];
  assign o_key_press   = press_q;
  assign o_key_release = release_q;
  assign o_key_sticky  = sticky_q;

endmodule

// File: tb/tb_io_input_debouncer.sv
// Directed bench for io_input_debouncer with DEBOUNCE_CYCLES=4.
module tb_io_input_debouncer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] sw;
  logic [3:0] key;
  logic [3:0] clr;
  logic [9:0] o_sw;
  logic [3:0] o_lvl, o_prs, o_rel, o_stk;

  int tests = 0;
  int fails = 0;
  int press_cnt [4];
  int rel_cnt   [4];

  always #5 clk = ~clk;

  io_input_debouncer #(
    .NUM_SW(10), .NUM_KEY(4), .DEBOUNCE_CYCLES(4)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .i_sw(sw), .i_key(key), .i_clr_key(clr),
    .o_sw(o_sw), .o_key_level(o_lvl), .o_key_press(o_prs),
    .o_key_release(o_rel), .o_key_sticky(o_stk)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr_counts();
    for (int i = 0; i < 4; i++) begin
      press_cnt[i] = 0;
      rel_cnt[i]   = 0;
    end
  endtask

  // Advance n edges, sampling 1 ns after each edge and tallying pulses.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        press_cnt[i] += int'(o_prs[i]);
        rel_cnt[i]   += int'(o_rel[i]);
      end
      if ((o_prs & o_rel) != 4'h0) chk("press_and_release", {28'h0, o_prs & o_rel}, 32'h0);
    end
  endtask

  initial begin
    clr_counts();
    rst_n = 1'b0; sw = 10'h3FF; key = 4'h0; clr = 4'h0;

    // 1. reset and power-up
    tick(3);
    chk("rst_sw",     {22'h0, o_sw}, 32'h0);
    chk("rst_lvl",    {28'h0, o_lvl}, 32'h0);
    chk("rst_prs",    {28'h0, o_prs}, 32'h0);
    chk("rst_rel",    {28'h0, o_rel}, 32'h0);
    chk("rst_stk",    {28'h0, o_stk}, 32'h0);
    rst_n = 1'b1;
    tick(5);
    chk("pu_sw_e5",   {22'h0, o_sw}, 32'h0);
    chk("pu_lvl_e5",  {28'h0, o_lvl}, 32'h0);
    tick(1);
    chk("pu_sw_e6",   {22'h0, o_sw}, 32'h3FF);
    chk("pu_lvl_e6",  {28'h0, o_lvl}, 32'hF);
    chk("pu_prs_e6",  {28'h0, o_prs}, 32'hF);
    chk("pu_stk_e6",  {28'h0, o_stk}, 32'hF);
    tick(1);
    chk("pu_prs_e7",  {28'h0, o_prs}, 32'h0);
    chk("pu_stk_e7",  {28'h0, o_stk}, 32'hF);

    // release all keys, drop switches, clear sticky
    key = 4'hF; sw = 10'h000;
    tick(5);
    chk("rel_lvl_e5", {28'h0, o_lvl}, 32'hF);
    tick(1);
    chk("rel_lvl_e6", {28'h0, o_lvl}, 32'h0);
    chk("rel_rel_e6", {28'h0, o_rel}, 32'hF);
    chk("rel_sw_e6",  {22'h0, o_sw}, 32'h0);
    tick(1);
    chk("rel_rel_e7", {28'h0, o_rel}, 32'h0);
    chk("rel_stk_held", {28'h0, o_stk}, 32'hF);
    clr = 4'hF;
    tick(1);
    clr = 4'h0;
    chk("clr_all_stk", {28'h0, o_stk}, 32'h0);

    // 2. clean switch edge on bit 3
    sw = 10'h008;
    tick(5);
    chk("sw3_rise_e5", {22'h0, o_sw}, 32'h000);
    tick(1);
    chk("sw3_rise_e6", {22'h0, o_sw}, 32'h008);
    tick(3);
    sw = 10'h000;
    tick(5);
    chk("sw3_fall_e5", {22'h0, o_sw}, 32'h008);
    tick(1);
    chk("sw3_fall_e6", {22'h0, o_sw}, 32'h000);

    // 3. bouncing key 1
    clr_counts();
    key = 4'b1101;
    tick(3);
    key = 4'b1111;
    tick(1);
    key = 4'b1101;
    tick(5);
    chk("k1_bounce_e5", {31'h0, o_lvl[1]}, 32'h0);
    tick(1);
    chk("k1_bounce_e6", {31'h0, o_lvl[1]}, 32'h1);
    tick(3);
    chk("k1_press_cnt", press_cnt[1], 32'd1);
    chk("k1_rel_cnt",   rel_cnt[1],   32'd0);

    // 4. press/release pulses and sticky on key 2
    clr_counts();
    key = 4'b1001;
    tick(20);
    key = 4'b1101;
    tick(6);
    chk("k2_rel_e6",    {31'h0, o_rel[2]}, 32'h1);
    tick(1);
    chk("k2_rel_e7",    {31'h0, o_rel[2]}, 32'h0);
    chk("k2_press_cnt", press_cnt[2], 32'd1);
    chk("k2_rel_cnt",   rel_cnt[2],   32'd1);
    chk("k2_stk_held",  {28'h0, o_stk}, 32'b0110);
    clr = 4'b0100;
    tick(1);
    clr = 4'b0000;
    chk("k2_stk_clr",   {28'h0, o_stk}, 32'b0010);

    // 5. clear coincident with press on key 0
    key = 4'b1100;
    tick(5);
    clr = 4'b0001;
    tick(1);
    chk("k0_prs_e6",    {31'h0, o_prs[0]}, 32'h1);
    chk("k0_stk_setwin", {31'h0, o_stk[0]}, 32'h1);
    clr = 4'b0000;
    tick(1);
    chk("k0_stk_kept",  {31'h0, o_stk[0]}, 32'h1);
    clr = 4'b0001;
    tick(1);
    clr = 4'b0000;
    chk("k0_stk_clr",   {31'h0, o_stk[0]}, 32'h0);

    // 6. reset in the middle of a switch count
    sw = 10'h001;
    tick(2);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("mid_rst_sw",   {22'h0, o_sw}, 32'h0);
    chk("mid_rst_lvl",  {28'h0, o_lvl}, 32'h0);
    chk("mid_rst_stk",  {28'h0, o_stk}, 32'h0);
    tick(3);
    chk("mid_rst_e3",   {22'h0, o_sw}, 32'h0);
    tick(2);
    chk("mid_rst_e5",   {22'h0, o_sw}, 32'h0);
    tick(1);
    chk("mid_rst_e6",   {22'h0, o_sw}, 32'h001);
    chk("mid_rst_lvl6", {28'h0, o_lvl}, 32'b0011);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
